knight_anim_ctrl: RTL and testbench

KNIGHT_ANIM_CTRL -- requirements
Module: knight_anim_ctrl

---
 rtl/knight_anim_ctrl.sv | 140 ++++++++++++++
 tb/tb_knight_anim_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_anim_ctrl.sv
// knight_anim_ctrl: knight sprite animation FSM (idle/walk/attack/recover) and pixel-to-ROM address mapping.
module knight_anim_ctrl #(
  parameter int SPR_W  = 50,
  parameter int SPR_H  = 64,
  parameter int N_ATK  = 4,
  parameter int N_WALK = 4,
  parameter int HOLD   = 6,
  localparam int FW = $clog2(N_WALK + N_ATK + 1)
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          attack_req,
  input  logic          walk,
  input  logic          facing_left,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    knight_x,
  input  logic [9:0]    knight_y,
  output logic [11:0]   rom_address,
  output logic [FW-1:0] frame_sel,
  output logic          in_sprite,
  output logic          attack_busy,
  output logic          attack_done
);
  localparam int IW = $clog2((N_ATK > N_WALK ? N_ATK : N_WALK) + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [IW-1:0] ATK_LAST  = IW'(N_ATK - 1);
  localparam logic [IW-1:0] WALK_LAST = IW'(N_WALK - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [FW-1:0] ATK_BASE  = FW'(N_WALK + 1);
  localparam logic [9:0]    W10 = 10'(SPR_W);
  localparam logic [9:0]    H10 = 10'(SPR_H);
  localparam logic [11:0]   W12 = 12'(SPR_W);

  typedef enum logic [1:0] {IDLE, WALK, ATTACK, RECOVER} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [HW-1:0] hold;
  logic          pending;
  logic          rec_entry;
  logic          req;

  // a request on the frame_start cycle itself counts for that transition
  assign req = pending | attack_req;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      rec_entry   <= 1'b0;
      frame_sel   <= '0;
      attack_busy <= 1'b0;
      attack_done <= 1'b0;
    end else begin
      attack_done <= rec_entry;
      rec_entry   <= 1'b0;
      if (attack_req && (state == IDLE || state == WALK)) pending <= 1'b1;
      if (frame_start) begin
        case (state)
          IDLE, RECOVER: begin
            idx  <= '0;
            hold <= '0;
            if (state == IDLE && req) begin
              state       <= ATTACK;
              pending     <= 1'b0;
              frame_sel   <= ATK_BASE;
              attack_busy <= 1'b1;
            end else begin
              state     <= walk ? WALK : IDLE;
              frame_sel <= walk ? FW'(1) : '0;
            end
          end
          WALK: begin
            if (req) begin
              state       <= ATTACK;
              idx         <= '0;
              hold        <= '0;
              pending     <= 1'b0;
              frame_sel   <= ATK_BASE;
              attack_busy <= 1'b1;
            end else if (!walk) begin
              state     <= IDLE;
              idx       <= '0;
              hold      <= '0;
              frame_sel <= '0;
            end else if (hold == HOLD_LAST) begin
              hold      <= '0;
              idx       <= (idx == WALK_LAST) ? '0 : idx + 1'b1;
              frame_sel <= (idx == WALK_LAST) ? FW'(1) : FW'(idx) + FW'(2);
            end else begin
              hold <= hold + 1'b1;
            end
          end
          ATTACK: begin
            if (hold == HOLD_LAST) begin
              hold <= '0;
              if (idx == ATK_LAST) begin
                state       <= RECOVER;
                idx         <= '0;
                frame_sel   <= '0;
                attack_busy <= 1'b0;
                rec_entry   <= 1'b1;
              end else begin
                idx       <= idx + 1'b1;
                frame_sel <= ATK_BASE + FW'(idx) + FW'(1);
              end
            end else begin
              hold <= hold + 1'b1;
            end
          end
        endcase
      end
    end
  end

  logic [9:0]  lx, ly, cx;
  logic        hit;
  logic [11:0] addr;

  // negative offsets wrap to large values and fall outside the sprite
  assign lx   = DrawX - knight_x;
  assign ly   = DrawY - knight_y;
  assign hit  = (lx < W10) && (ly < H10);
  assign cx   = facing_left ? W10 - 10'd1 - lx : lx;
  assign addr = {2'b00, ly} * W12 + {2'b00, cx};

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_sprite   <= 1'b0;
      rom_address <= '0;
    end else begin
      in_sprite   <= hit;
      rom_address <= hit ? addr : '0;
    end
  end
endmodule

// File: tb/tb_knight_anim_ctrl.sv
// tb_knight_anim_ctrl: pixel vector table, hand-written animation sequences and a randomized run against a frame-count model.
module tb_knight_anim_ctrl;
  localparam int SPR_W = 50, SPR_H = 64, N_ATK = 4, N_WALK = 4, HOLD = 6;

  logic        vga_clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0;
  logic        attack_req = 1'b0, walk = 1'b0, facing_left = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, knight_x = '0, knight_y = '0;
  logic [11:0] rom_address;
  logic [3:0]  frame_sel;
  logic        in_sprite, attack_busy, attack_done;

  int tests = 0, fails = 0, done_seen = 0;
  int m_mode, m_cnt, m_edge = 0, m_rec_edge;
  bit m_pend;
  int e_in, e_addr, e_done;

  always #5 vga_clk = ~vga_clk;

  knight_anim_ctrl #(.SPR_W(SPR_W), .SPR_H(SPR_H), .N_ATK(N_ATK), .N_WALK(N_WALK), .HOLD(HOLD)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start), .attack_req(attack_req),
    .walk(walk), .facing_left(facing_left), .DrawX(DrawX), .DrawY(DrawY),
    .knight_x(knight_x), .knight_y(knight_y), .rom_address(rom_address),
    .frame_sel(frame_sel), .in_sprite(in_sprite), .attack_busy(attack_busy), .attack_done(attack_done)
  );

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 walk, 2 attack, 3 recover; m_cnt = frame_starts since entering the mode
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pend = 0; m_rec_edge = -10;
    e_in = 0; e_addr = 0; e_done = 0;
  endtask

  function automatic int exp_sel();
    if (m_mode == 1) return 1 + (m_cnt / HOLD) % N_WALK;
    if (m_mode == 2) return 1 + N_WALK + m_cnt / HOLD;
    return 0;
  endfunction

  task automatic model_step();
    int lx, ly, cx;
    bit rq;
    m_edge++;
    e_done = (m_edge == m_rec_edge + 1) ? 1 : 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    lx = (int'(DrawX) - int'(knight_x)) & 1023;
    ly = (int'(DrawY) - int'(knight_y)) & 1023;
    e_in = (lx < SPR_W && ly < SPR_H) ? 1 : 0;
    cx = facing_left ? SPR_W - 1 - lx : lx;
    e_addr = e_in ? (ly * SPR_W + cx) % 4096 : 0;
    rq = m_pend || attack_req;
    if (attack_req && m_mode < 2) m_pend = 1;
    if (frame_start) begin
      case (m_mode)
        0: if (rq) begin m_mode = 2; m_cnt = 0; m_pend = 0; end
           else if (walk) begin m_mode = 1; m_cnt = 0; end
        1: if (rq) begin m_mode = 2; m_cnt = 0; m_pend = 0; end
           else if (!walk) begin m_mode = 0; m_cnt = 0; end
           else m_cnt++;
        2: begin
          m_cnt++;
          if (m_cnt == N_ATK * HOLD) begin m_mode = 3; m_cnt = 0; m_rec_edge = m_edge; end
        end
        default: begin m_mode = walk ? 1 : 0; m_cnt = 0; end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    model_step();
    #1;
    if (attack_done) done_seen++;
  endtask

  task automatic compare_all(string tag);
    chk({tag, " frame_sel"}, frame_sel, exp_sel());
    chk({tag, " attack_busy"}, attack_busy, m_mode == 2);
    chk({tag, " attack_done"}, attack_done, e_done);
    chk({tag, " in_sprite"}, in_sprite, e_in);
    chk({tag, " rom_address"}, rom_address, e_addr);
  endtask

  task automatic check_zero(string tag);
    chk({tag, " frame_sel"}, frame_sel, 0);
    chk({tag, " rom_address"}, rom_address, 0);
    chk({tag, " in_sprite"}, in_sprite, 0);
    chk({tag, " attack_busy"}, attack_busy, 0);
    chk({tag, " attack_done"}, attack_done, 0);
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  dx, dy, kx, ky;
    logic        fl;
    logic        ein;
    logic [11:0] ea;
  } pix_t;

  initial begin
    pix_t pv[9];
    int s;
    pv[0] = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b0, 1'b1, 12'd0};
    pv[1] = '{10'd149, 10'd263, 10'd100, 10'd200, 1'b0, 1'b1, 12'd3199};
    pv[2] = '{10'd99,  10'd200, 10'd100, 10'd200, 1'b0, 1'b0, 12'd0};
    pv[3] = '{10'd150, 10'd200, 10'd100, 10'd200, 1'b0, 1'b0, 12'd0};
    pv[4] = '{10'd100, 10'd201, 10'd100, 10'd200, 1'b1, 1'b1, 12'd99};
    pv[5] = '{10'd120, 10'd264, 10'd100, 10'd200, 1'b0, 1'b0, 12'd0};
    pv[6] = '{10'd110, 10'd210, 10'd100, 10'd200, 1'b0, 1'b1, 12'd510};
    pv[7] = '{10'd5,   10'd5,   10'd1000, 10'd1000, 1'b0, 1'b1, 12'd1479};
    pv[8] = '{10'd149, 10'd263, 10'd100, 10'd200, 1'b1, 1'b1, 12'd3150};
    model_reset();

    // reset state, before any clock edge
    #3;
    check_zero("reset");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset frame_sel", frame_sel, 0);

    // pixel table
    for (int i = 0; i < 9; i++) begin
      DrawX = pv[i].dx; DrawY = pv[i].dy; knight_x = pv[i].kx; knight_y = pv[i].ky;
      facing_left = pv[i].fl;
      tick();
      chk($sformatf("pix%0d in_sprite", i), in_sprite, pv[i].ein);
      chk($sformatf("pix%0d rom_address", i), rom_address, pv[i].ea);
    end
    // one-cycle latency: new pixel not visible before the edge
    facing_left = 1'b0; DrawX = 10'd99; DrawY = 10'd200; knight_x = 10'd100; knight_y = 10'd200;
    tick();
    DrawX = 10'd101; DrawY = 10'd202;
    #2;
    chk("latency pre in_sprite", in_sprite, 0);
    tick();
    chk("latency post in_sprite", in_sprite, 1);
    chk("latency post rom_address", rom_address, 101);

    // idle attack
    walk = 1'b0;
    attack_req = 1'b1; tick(); attack_req = 1'b0; tick();
    chk("pend frame_sel", frame_sel, 0);
    chk("pend busy", attack_busy, 0);
    done_seen = 0;
    for (int k = 1; k <= 1 + N_ATK * HOLD; k++) begin
      s = (k <= N_ATK * HOLD) ? 5 + (k - 1) / HOLD : 0;
      fs();
      chk("atk frame_sel", frame_sel, s);
      chk("atk busy", attack_busy, k <= N_ATK * HOLD);
      tick();
      if (k == 1 + N_ATK * HOLD) chk("atk done pulse", attack_done, 1);
      tick();
      chk("atk hold frame_sel", frame_sel, s);
      chk("atk done width", attack_done, 0);
    end
    fs();
    chk("atk end frame_sel", frame_sel, 0);
    chk("atk done count", done_seen, 1);

    // walk wrap
    walk = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      s = 1 + ((k - 1) / HOLD) % N_WALK;
      fs();
      chk("walk frame_sel", frame_sel, s);
      repeat (2) tick();
      chk("walk hold frame_sel", frame_sel, s);
    end
    walk = 1'b0;
    fs();
    chk("walk exit frame_sel", frame_sel, 0);

    // drop: request with frame_start enters at once; later requests are dropped
    done_seen = 0;
    attack_req = 1'b1; fs(); attack_req = 1'b0;
    chk("same-cycle req frame_sel", frame_sel, 5);
    for (int k = 1; k <= N_ATK * HOLD; k++) begin
      attack_req = (k % 5 == 0); tick(); attack_req = 1'b0;
      if (k == 7) attack_req = 1'b1;
      fs(); attack_req = 1'b0;
    end
    chk("drop recover frame_sel", frame_sel, 0);
    attack_req = 1'b1; tick(); attack_req = 1'b0;
    repeat (3) begin fs(); tick(); end
    chk("drop frame_sel", frame_sel, 0);
    chk("drop busy", attack_busy, 0);
    chk("drop done count", done_seen, 1);

    // queue: request between frame_starts in WALK
    walk = 1'b1;
    fs();
    chk("queue walk frame_sel", frame_sel, 1);
    tick(); attack_req = 1'b1; tick(); attack_req = 1'b0;
    repeat (3) tick();
    chk("queue wait frame_sel", frame_sel, 1);
    fs();
    chk("queue atk frame_sel", frame_sel, 5);
    chk("queue atk busy", attack_busy, 1);
    repeat (N_ATK * HOLD) begin fs(); tick(); end
    chk("queue recover frame_sel", frame_sel, 0);
    fs();
    chk("recover to walk frame_sel", frame_sel, 1);

    // reset abort during attack frame 2
    walk = 1'b0;
    fs();
    attack_req = 1'b1; fs(); attack_req = 1'b0;
    repeat (2 * HOLD) begin tick(); fs(); end
    chk("abort pre frame_sel", frame_sel, 7);
    done_seen = 0;
    DrawX = 10'd110; DrawY = 10'd210;
    #2 reset_n = 1'b0;
    #1;
    check_zero("abort async");
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("abort release frame_sel", frame_sel, 0);
    chk("abort release busy", attack_busy, 0);
    chk("abort done count", done_seen, 0);
    walk = 1'b1;
    fs();
    chk("abort restart frame_sel", frame_sel, 1);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        knight_x = 10'($urandom_range(0, 1023));
        knight_y = 10'($urandom_range(0, 1023));
      end
      frame_start = ($urandom_range(0, 3) == 0);
      attack_req  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) walk = ~walk;
      facing_left = 1'($urandom_range(0, 1));
      DrawX = knight_x + 10'($urandom_range(0, 60)) - 10'd5;
      DrawY = knight_y + 10'($urandom_range(0, 72)) - 10'd4;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero("rand reset");
        tick();
        reset_n = 1'b1;
      end
      tick();
      compare_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
